// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg
//   Shared definitions for the video RAM arbiter:
//   - default address/data widths
//   - CPU-side FSM state encoding
//   - saturation limit and saturating increment for the conflict counter
package vram_arbiter_pkg;

    localparam int AW_DEFAULT = 13;
    localparam int DW_DEFAULT = 8;

    localparam logic [15:0] CONFLICTS_MAX = 16'hFFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } cpu_state_t;

    function automatic logic [15:0] conflicts_inc(input logic [15:0] cnt);
        return (cnt == CONFLICTS_MAX) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/vram_wfifo.sv
// vram_wfifo
//   Two-entry posted-write FIFO (address + data). Push and pop may happen
//   in the same cycle; the caller never pushes when full or pops when empty.
// Ports:
//   clock, reset       single clock, synchronous active-high reset
//   push, push_a/d     enqueue one write
//   pop                dequeue the head entry
//   full, empty        occupancy flags for the current cycle
//   head_a, head_d     oldest buffered write
module vram_wfifo #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [AW-1:0] push_a,
    input  logic [DW-1:0] push_d,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] head_a,
    output logic [DW-1:0] head_d
);

    logic [AW-1:0] a_q [2];
    logic [AW-1:0] a_d [2];
    logic [DW-1:0] d_q [2];
    logic [DW-1:0] d_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;

    assign full   = (count_q == 2'd2);
    assign empty  = (count_q == 2'd0);
    assign head_a = a_q[rd_ptr_q];
    assign head_d = d_q[rd_ptr_q];

    always_comb begin
        a_d      = a_q;
        d_d      = d_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            a_d[wr_ptr_q] = push_a;
            d_d[wr_ptr_q] = push_d;
            wr_ptr_d      = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q      <= '{default: '0};
            d_q      <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            a_q      <= a_d;
            d_q      <= d_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares one single-port synchronous video RAM between a VGA scanout
//   reader (absolute priority, never stalled) and a CPU (request/ready).
//   Optional feature macro: VRAM_WRITE_BUFFER_EN adds a 2-entry posted-write
//   FIFO (vram_wfifo) so CPU writes can complete while VGA holds the port.
// Ports:
//   clock, reset                   single clock, synchronous active-high reset
//   vga_req, vga_a                 VGA read strobe and address
//   vga_q, vga_valid               VGA read data and its one-cycle strobe
//   cpu_re, cpu_we, cpu_a, cpu_d   CPU level requests, address, write data
//   cpu_q, cpu_ready               CPU read data and completion pulse
//   ram_a, ram_d, ram_we, ram_q    RAM port (1-cycle read latency)
//   conflicts                      saturating count of VGA-denied CPU cycles
//
// CPU FSM states:
//   state   | meaning
//   ST_IDLE | waiting for a CPU request; issue it when the port is free
//   ST_ACK  | access completed last cycle; pulse cpu_ready, capture read data
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_a,
    output logic [DW-1:0] vga_q,
    output logic          vga_valid,
    input  logic          cpu_re,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_d,
    output logic [DW-1:0] cpu_q,
    output logic          cpu_ready,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,
    output logic [15:0]   conflicts
);

    cpu_state_t    state_q, state_d;
    logic          ack_rd_q, ack_rd_d;
    logic          cpu_ready_q, cpu_ready_d;
    logic          vga_valid_q, vga_valid_d;
    logic [DW-1:0] cpu_q_q, cpu_q_d;
    logic [DW-1:0] vga_q_q, vga_q_d;
    logic [15:0]   conflicts_q, conflicts_d;

`ifdef VRAM_WRITE_BUFFER_EN
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [AW-1:0] fifo_head_a;
    logic [DW-1:0] fifo_head_d;

    vram_wfifo #(
        .AW(AW),
        .DW(DW)
    ) u_wfifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .push_a(cpu_a),
        .push_d(cpu_d),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head_a(fifo_head_a),
        .head_d(fifo_head_d)
    );
`endif

    // Strobes are masked by reset so an access issued just before reset
    // never reports completion. Read data is presented in the strobe cycle
    // straight from the RAM and held in a register afterwards.
    assign cpu_ready = cpu_ready_q & ~reset;
    assign vga_valid = vga_valid_q & ~reset;
    assign cpu_q     = (cpu_ready && ack_rd_q) ? ram_q : cpu_q_q;
    assign vga_q     = vga_valid ? ram_q : vga_q_q;
    assign conflicts = conflicts_q;

    always_comb begin
        state_d     = state_q;
        ack_rd_d    = ack_rd_q;
        cpu_ready_d = 1'b0;
        vga_valid_d = vga_req;
        cpu_q_d     = cpu_q_q;
        vga_q_d     = vga_q_q;
        conflicts_d = conflicts_q;
        ram_a       = vga_a;
        ram_d       = '0;
        ram_we      = 1'b0;
`ifdef VRAM_WRITE_BUFFER_EN
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
`endif

        if (vga_valid_q) begin
            vga_q_d = ram_q;
        end

        if (state_q == ST_ACK) begin
            if (ack_rd_q) begin
                cpu_q_d = ram_q;
            end
            state_d = ST_IDLE;
        end

`ifdef VRAM_WRITE_BUFFER_EN
        // Port order: VGA, then oldest buffered write, then CPU read.
        if (!vga_req && !fifo_empty) begin
            ram_a    = fifo_head_a;
            ram_d    = fifo_head_d;
            ram_we   = 1'b1;
            fifo_pop = 1'b1;
        end

        if (state_q == ST_IDLE && (cpu_re || cpu_we)) begin
            if (cpu_we) begin
                if (!fifo_full) begin
                    fifo_push   = 1'b1;
                    state_d     = ST_ACK;
                    cpu_ready_d = 1'b1;
                    ack_rd_d    = 1'b0;
                end
            end else if (fifo_empty) begin
                // Reads stalled behind buffered writes are not VGA conflicts.
                if (vga_req) begin
                    conflicts_d = conflicts_inc(conflicts_q);
                end else begin
                    ram_a       = cpu_a;
                    state_d     = ST_ACK;
                    cpu_ready_d = 1'b1;
                    ack_rd_d    = 1'b1;
                end
            end
        end
`else
        if (state_q == ST_IDLE && (cpu_re || cpu_we)) begin
            if (vga_req) begin
                conflicts_d = conflicts_inc(conflicts_q);
            end else begin
                ram_a       = cpu_a;
                ram_d       = cpu_d;
                ram_we      = cpu_we;
                state_d     = ST_ACK;
                cpu_ready_d = 1'b1;
                ack_rd_d    = ~cpu_we;
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ack_rd_q    <= 1'b0;
            cpu_ready_q <= 1'b0;
            vga_valid_q <= 1'b0;
            cpu_q_q     <= '0;
            vga_q_q     <= '0;
            conflicts_q <= '0;
        end else begin
            state_q     <= state_d;
            ack_rd_q    <= ack_rd_d;
            cpu_ready_q <= cpu_ready_d;
            vga_valid_q <= vga_valid_d;
            cpu_q_q     <= cpu_q_d;
            vga_q_q     <= vga_q_d;
            conflicts_q <= conflicts_d;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//   Self-checking bench for vram_arbiter: a per-cycle vector table for the
//   default build, a long denial run for counter saturation, and (when
//   VRAM_WRITE_BUFFER_EN is defined) a posted-write sequence.
module tb_vram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        vga_req;
    logic [12:0] vga_a;
    logic [7:0]  vga_q;
    logic        vga_valid;
    logic        cpu_re, cpu_we;
    logic [12:0] cpu_a;
    logic [7:0]  cpu_d;
    logic [7:0]  cpu_q;
    logic        cpu_ready;
    logic [12:0] ram_a;
    logic [7:0]  ram_d;
    logic        ram_we;
    logic [7:0]  ram_q;
    logic [15:0] conflicts;
    logic        preload;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    vram_arbiter dut (
        .clock    (clock),
        .reset    (reset),
        .vga_req  (vga_req),
        .vga_a    (vga_a),
        .vga_q    (vga_q),
        .vga_valid(vga_valid),
        .cpu_re   (cpu_re),
        .cpu_we   (cpu_we),
        .cpu_a    (cpu_a),
        .cpu_d    (cpu_d),
        .cpu_q    (cpu_q),
        .cpu_ready(cpu_ready),
        .ram_a    (ram_a),
        .ram_d    (ram_d),
        .ram_we   (ram_we),
        .ram_q    (ram_q),
        .conflicts(conflicts)
    );

    // Single-port synchronous RAM, one-cycle read latency.
    logic [7:0] mem [0:8191];
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
            mem[13'h0100] <= 8'h5A;
            mem[13'h0200] <= 8'h11;
            mem[13'h0201] <= 8'h22;
            mem[13'h0202] <= 8'h33;
            mem[13'h0300] <= 8'h77;
        end else if (ram_we) begin
            mem[ram_a] <= ram_d;
        end
        ram_q <= mem[ram_a];
    end

    typedef struct {
        logic        rst;
        logic        vreq;
        logic [12:0] va;
        logic        cre;
        logic        cwe;
        logic [12:0] ca;
        logic [7:0]  cd;
        logic [12:0] e_ra;
        logic        e_we;
        logic [7:0]  e_rd;
        logic        e_rdy;
        logic [7:0]  e_cq;
        logic        e_vv;
        logic [7:0]  e_vq;
        logic [15:0] e_conf;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic rst, input logic vreq, input logic [12:0] va,
        input logic cre, input logic cwe, input logic [12:0] ca, input logic [7:0] cd,
        input logic [12:0] e_ra, input logic e_we, input logic [7:0] e_rd,
        input logic e_rdy, input logic [7:0] e_cq, input logic e_vv,
        input logic [7:0] e_vq, input logic [15:0] e_conf);
        vec_t v;
        v.rst = rst; v.vreq = vreq; v.va = va; v.cre = cre; v.cwe = cwe;
        v.ca = ca; v.cd = cd; v.e_ra = e_ra; v.e_we = e_we; v.e_rd = e_rd;
        v.e_rdy = e_rdy; v.e_cq = e_cq; v.e_vv = e_vv; v.e_vq = e_vq;
        v.e_conf = e_conf;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rst, input logic vreq, input logic [12:0] va,
                         input logic cre, input logic cwe, input logic [12:0] ca,
                         input logic [7:0] cd);
        reset = rst; vga_req = vreq; vga_a = va;
        cpu_re = cre; cpu_we = cwe; cpu_a = ca; cpu_d = cd;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic ready_seen;

        //               rst vr va       re we ca       cd       ra       we rd     rdy cq     vv vq     conf
        vecs[0]  = mk(0, 0, 13'h0000, 0, 0, 13'h0000, 8'h00, 13'h0000, 0, 8'h00, 0, 8'h00, 0, 8'h00, 16'd0);
        vecs[1]  = mk(0, 0, 13'h0000, 1, 0, 13'h0100, 8'h00, 13'h0100, 0, 8'h00, 0, 8'h00, 0, 8'h00, 16'd0);
        vecs[2]  = mk(0, 0, 13'h0000, 0, 0, 13'h0000, 8'h00, 13'h0000, 0, 8'h00, 1, 8'h5A, 0, 8'h00, 16'd0);
        vecs[3]  = mk(0, 0, 13'h0000, 0, 0, 13'h0000, 8'h00, 13'h0000, 0, 8'h00, 0, 8'h5A, 0, 8'h00, 16'd0);
        vecs[4]  = mk(0, 1, 13'h0200, 1, 0, 13'h0300, 8'h00, 13'h0200, 0, 8'h00, 0, 8'h5A, 0, 8'h00, 16'd0);
        vecs[5]  = mk(0, 1, 13'h0201, 1, 0, 13'h0300, 8'h00, 13'h0201, 0, 8'h00, 0, 8'h5A, 1, 8'h11, 16'd1);
        vecs[6]  = mk(0, 1, 13'h0202, 1, 0, 13'h0300, 8'h00, 13'h0202, 0, 8'h00, 0, 8'h5A, 1, 8'h22, 16'd2);
        vecs[7]  = mk(0, 0, 13'h0000, 1, 0, 13'h0300, 8'h00, 13'h0300, 0, 8'h00, 0, 8'h5A, 1, 8'h33, 16'd3);
        vecs[8]  = mk(0, 0, 13'h0000, 1, 0, 13'h0300, 8'h00, 13'h0000, 0, 8'h00, 1, 8'h77, 0, 8'h33, 16'd3);
        vecs[9]  = mk(0, 0, 13'h0000, 0, 0, 13'h0000, 8'h00, 13'h0000, 0, 8'h00, 0, 8'h77, 0, 8'h33, 16'd3);
        vecs[10] = mk(0, 0, 13'h0000, 0, 1, 13'h1800, 8'hC3, 13'h1800, 1, 8'hC3, 0, 8'h77, 0, 8'h33, 16'd3);
        vecs[11] = mk(0, 0, 13'h0000, 0, 0, 13'h0000, 8'h00, 13'h0000, 0, 8'h00, 1, 8'h77, 0, 8'h33, 16'd3);
        vecs[12] = mk(0, 0, 13'h0000, 1, 0, 13'h1800, 8'h00, 13'h1800, 0, 8'h00, 0, 8'h77, 0, 8'h33, 16'd3);
        vecs[13] = mk(0, 0, 13'h0000, 0, 0, 13'h0000, 8'h00, 13'h0000, 0, 8'h00, 1, 8'hC3, 0, 8'h33, 16'd3);
        vecs[14] = mk(0, 0, 13'h0000, 1, 1, 13'h0400, 8'h9E, 13'h0400, 1, 8'h9E, 0, 8'hC3, 0, 8'h33, 16'd3);
        vecs[15] = mk(0, 0, 13'h0000, 0, 0, 13'h0000, 8'h00, 13'h0000, 0, 8'h00, 1, 8'hC3, 0, 8'h33, 16'd3);
        vecs[16] = mk(0, 1, 13'h0100, 0, 1, 13'h0500, 8'h44, 13'h0100, 0, 8'h00, 0, 8'hC3, 0, 8'h33, 16'd3);
        vecs[17] = mk(0, 0, 13'h0000, 0, 1, 13'h0500, 8'h44, 13'h0500, 1, 8'h44, 0, 8'hC3, 1, 8'h5A, 16'd4);
        vecs[18] = mk(0, 0, 13'h0000, 0, 0, 13'h0000, 8'h00, 13'h0000, 0, 8'h00, 1, 8'hC3, 0, 8'h5A, 16'd4);
        vecs[19] = mk(0, 1, 13'h0400, 0, 0, 13'h0000, 8'h00, 13'h0400, 0, 8'h00, 0, 8'hC3, 0, 8'h5A, 16'd4);
        vecs[20] = mk(0, 0, 13'h0000, 0, 0, 13'h0000, 8'h00, 13'h0000, 0, 8'h00, 0, 8'hC3, 1, 8'h9E, 16'd4);
        vecs[21] = mk(0, 1, 13'h0200, 1, 0, 13'h0300, 8'h00, 13'h0200, 0, 8'h00, 0, 8'hC3, 0, 8'h9E, 16'd4);
        vecs[22] = mk(0, 0, 13'h0000, 1, 0, 13'h0300, 8'h00, 13'h0300, 0, 8'h00, 0, 8'hC3, 1, 8'h11, 16'd5);
        vecs[23] = mk(1, 0, 13'h0000, 0, 0, 13'h0000, 8'h00, 13'h0000, 0, 8'h00, 0, 8'hC3, 0, 8'h11, 16'd5);
        vecs[24] = mk(0, 0, 13'h0000, 0, 0, 13'h0000, 8'h00, 13'h0000, 0, 8'h00, 0, 8'h00, 0, 8'h00, 16'd0);
        vecs[25] = mk(0, 0, 13'h0000, 1, 0, 13'h0100, 8'h00, 13'h0100, 0, 8'h00, 0, 8'h00, 0, 8'h00, 16'd0);
        vecs[26] = mk(0, 0, 13'h0000, 0, 0, 13'h0000, 8'h00, 13'h0000, 0, 8'h00, 1, 8'h5A, 0, 8'h00, 16'd0);
        vecs[27] = mk(0, 1, 13'h0201, 0, 0, 13'h0000, 8'h00, 13'h0201, 0, 8'h00, 0, 8'h5A, 0, 8'h00, 16'd0);
        vecs[28] = mk(1, 0, 13'h0000, 0, 0, 13'h0000, 8'h00, 13'h0000, 0, 8'h00, 0, 8'h5A, 0, 8'h00, 16'd0);
        vecs[29] = mk(0, 0, 13'h0000, 0, 0, 13'h0000, 8'h00, 13'h0000, 0, 8'h00, 0, 8'h00, 0, 8'h00, 16'd0);

        preload = 1'b1;
        drive(1, 0, 13'h0, 0, 0, 13'h0, 8'h0);
        step;
        step;
        preload = 1'b0;

        for (int i = 0; i < NV; i++) begin
            step;
            drive(vecs[i].rst, vecs[i].vreq, vecs[i].va, vecs[i].cre, vecs[i].cwe,
                  vecs[i].ca, vecs[i].cd);
            #2;
            chk("ram_a",     i, 32'(ram_a),     32'(vecs[i].e_ra));
            chk("ram_we",    i, 32'(ram_we),    32'(vecs[i].e_we));
            if (vecs[i].e_we) chk("ram_d", i, 32'(ram_d), 32'(vecs[i].e_rd));
            chk("cpu_ready", i, 32'(cpu_ready), 32'(vecs[i].e_rdy));
            chk("cpu_q",     i, 32'(cpu_q),     32'(vecs[i].e_cq));
            chk("vga_valid", i, 32'(vga_valid), 32'(vecs[i].e_vv));
            chk("vga_q",     i, 32'(vga_q),     32'(vecs[i].e_vq));
            chk("conflicts", i, 32'(conflicts), 32'(vecs[i].e_conf));
        end

        // Saturation: 65534 denied cycles reach 0xFFFE, three more must stick at 0xFFFF.
        step;
        drive(1, 0, 13'h0, 0, 0, 13'h0, 8'h0);
        step;
        drive(0, 0, 13'h0, 0, 0, 13'h0, 8'h0);
        ready_seen = 1'b0;
        for (int i = 0; i < 65534; i++) begin
            step;
            drive(0, 1, 13'h0201, 1, 0, 13'h0300, 8'h00);
            #2;
            if (cpu_ready) ready_seen = 1'b1;
        end
        step;
        #2;
        chk("sat_fffe", 0, 32'(conflicts), 32'h0000FFFE);
        step;
        step;
        step;
        drive(0, 0, 13'h0, 1, 0, 13'h0300, 8'h00);
        #2;
        chk("sat_ffff", 0, 32'(conflicts), 32'h0000FFFF);
        chk("sat_issue", 0, 32'(ram_a), 32'h00000300);
        chk("sat_no_ready", 0, 32'(ready_seen), 32'h0);
        step;
        drive(0, 0, 13'h0, 0, 0, 13'h0, 8'h00);
        #2;
        chk("sat_ready", 0, 32'(cpu_ready), 32'h1);
        chk("sat_cpu_q", 0, 32'(cpu_q), 32'h77);
        chk("sat_hold", 0, 32'(conflicts), 32'h0000FFFF);

`ifdef VRAM_WRITE_BUFFER_EN
        // Posted writes under continuous VGA, then drain in order and read back.
        step;
        drive(1, 0, 13'h0, 0, 0, 13'h0, 8'h0);
        step;
        drive(0, 1, 13'h0, 0, 1, 13'h0600, 8'hA1);
        #2;
        chk("wb_no_we1", 0, 32'(ram_we), 32'h0);
        step;
        drive(0, 1, 13'h0, 0, 0, 13'h0, 8'h00);
        #2;
        chk("wb_ack1", 0, 32'(cpu_ready), 32'h1);
        step;
        drive(0, 1, 13'h0, 0, 1, 13'h0601, 8'hA2);
        step;
        drive(0, 1, 13'h0, 0, 0, 13'h0, 8'h00);
        #2;
        chk("wb_ack2", 0, 32'(cpu_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step;
            drive(0, 1, 13'h0, 0, 1, 13'h0602, 8'hA3);
            #2;
            chk("wb_wait_rdy", i, 32'(cpu_ready), 32'h0);
            chk("wb_wait_we", i, 32'(ram_we), 32'h0);
        end
        step;
        drive(0, 0, 13'h0, 0, 1, 13'h0602, 8'hA3);
        #2;
        chk("wb_drain1_we", 0, 32'(ram_we), 32'h1);
        chk("wb_drain1_a", 0, 32'(ram_a), 32'h0600);
        chk("wb_drain1_d", 0, 32'(ram_d), 32'hA1);
        chk("wb_drain1_rdy", 0, 32'(cpu_ready), 32'h0);
        step;
        #2;
        chk("wb_drain2_a", 0, 32'(ram_a), 32'h0601);
        chk("wb_drain2_d", 0, 32'(ram_d), 32'hA2);
        step;
        drive(0, 0, 13'h0, 0, 0, 13'h0, 8'h00);
        #2;
        chk("wb_ack3", 0, 32'(cpu_ready), 32'h1);
        chk("wb_drain3_a", 0, 32'(ram_a), 32'h0602);
        chk("wb_drain3_d", 0, 32'(ram_d), 32'hA3);
        step;
        drive(0, 0, 13'h0, 1, 0, 13'h0602, 8'h00);
        #2;
        chk("wb_rd_issue", 0, 32'(ram_a), 32'h0602);
        step;
        drive(0, 0, 13'h0, 0, 0, 13'h0, 8'h00);
        #2;
        chk("wb_rd_ready", 0, 32'(cpu_ready), 32'h1);
        chk("wb_rd_data", 0, 32'(cpu_q), 32'hA3);
        chk("wb_conflicts", 0, 32'(conflicts), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 13, video RAM address width.
REQ-002 SHALL have parameter DW, default 8, video RAM data width.
REQ-003 SHALL have port clock  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports vga_req input 1 read strobe; vga_a input AW address; vga_q output DW data; vga_valid output 1 data strobe.
REQ-006 SHALL have ports cpu_re input 1 read request (level); cpu_we input 1 write request (level); cpu_a input AW address; cpu_d input DW write data.
REQ-007 SHALL have ports cpu_q output DW read data; cpu_ready output 1 one-cycle completion pulse.
REQ-008 SHALL have ports ram_a output AW; ram_d output DW; ram_we output 1; ram_q input DW (single-port synchronous RAM, 1-cycle read latency).
REQ-009 SHALL have port conflicts output 16 count of cycles a pending CPU access was denied by VGA.

Function
REQ-010 SHALL give the RAM port to vga_req in any cycle it is high, with no wait and no loss, including back-to-back cycles.
REQ-011 SHALL drive ram_a/ram_d/ram_we combinationally from the current cycle's grant; ram_we=0 unless a write is granted.
REQ-012 SHALL register ram_q into vga_q and pulse vga_valid exactly one cycle after a VGA grant; vga_q holds until the next VGA read.
REQ-013 SHALL run a CPU FSM with states IDLE and ACK.
REQ-014 IDLE: on cpu_re or cpu_we with vga_req low, SHALL issue the access to RAM and go to ACK; with vga_req high, SHALL stay in IDLE and increment conflicts.
REQ-015 ACK: SHALL assert cpu_ready for exactly one cycle, load cpu_q from ram_q for reads (cpu_q unchanged for writes), ignore CPU inputs, and return to IDLE.
REQ-016 If cpu_re and cpu_we are both high, SHALL treat the request as a write.
REQ-017 conflicts SHALL saturate at 16'hFFFF, never wrap.
REQ-018 Minimum CPU access latency SHALL be 2 cycles (issue + ACK); each VGA-held cycle adds one.

Reset
REQ-019 On reset: FSM=IDLE, cpu_ready=0, vga_valid=0, cpu_q=0, vga_q=0, conflicts=0, write buffer emptied.
REQ-020 Reset mid-access SHALL abort it: no cpu_ready or vga_valid pulse for an access issued in the cycle before reset; buffered writes are discarded.

Configuration
REQ-021 Macro VRAM_WRITE_BUFFER_EN SHALL select the posted-write buffer.
REQ-022 Without the macro, writes SHALL follow REQ-014/015 exactly.
REQ-023 With the macro, a write in IDLE SHALL be pushed into a 2-entry FIFO when it holds fewer than 2 entries at the start of the cycle, regardless of vga_req, then go to ACK; when full, the write waits in IDLE.
REQ-024 With the macro, port priority SHALL be vga_req > FIFO drain (oldest first) > CPU read; push and drain may occur in the same cycle.
REQ-025 With the macro, a CPU read SHALL not be issued while the FIFO is non-empty (read-after-write ordering); such waits do not increment conflicts.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, AW/DW defaults, and the conflicts saturation constant.
REQ-027 The posted-write FIFO SHALL be a sub-module vram_wfifo, instantiated only under VRAM_WRITE_BUFFER_EN.

Verification
REQ-028 CPU read 0x0100 (RAM=0x5A), no VGA -> ram_a=0x0100 at cycle 0, cpu_ready and cpu_q=0x5A at cycle 1.
REQ-029 vga_req held 3 cycles while cpu_re pending -> 3 VGA grants, vga_valid 3 consecutive cycles, CPU issued cycle 3, cpu_ready cycle 4, conflicts=3.
REQ-030 CPU write 0x1800<-0xC3, then CPU read 0x1800 -> ram_we exactly one cycle, read returns 0xC3.
REQ-031 Reset asserted in the ACK cycle -> cpu_ready=0 that cycle and after, conflicts=0, FSM IDLE.
REQ-032 With VRAM_WRITE_BUFFER_EN: 3 writes under continuous vga_req -> first two acknowledged, third waits; after vga_req drops, writes land in order, then a read of the last address returns its data.
REQ-033 conflicts preloaded to 0xFFFE, 3 denied cycles -> conflicts=0xFFFF.
